csr_hpm: RTL

Parametrised machine-mode performance-counter bank that extends the core CSR file with `mcycle`/`minstret`, a configurable number of `mhpmcounterN`/`mhpmeventN` pairs, `mcountinhibit`, and overflow tracking with an interrupt request. It sits beside the main CSR unit and is addressed by the same memory1-stage CSR access port. It counts retirements and raw event pulses from the pipeline, and returns read data plus hit/error status to the CSR read mux in the same cycle.

---
 rtl/csr_hpm.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/csr_hpm.sv
// Machine-mode performance counters: mcycle, minstret, mhpmcounterN/mhpmeventN, mcountinhibit, overflow irq.
// Latency: reads/hit/error are combinational; writes and increments commit on the next clk_core edge; irq lags OF by one edge.
// Backpressure: none; every access completes in its own cycle and counting never stalls.
module csr_hpm #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_W      = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_core,
  input  logic                  reset,
  input  logic [11:0]           mem1_csr_addr,
  input  logic [1:0]            mem1_csr_write,
  input  logic [31:0]           mem1_csr_din,
  output logic                  hpm_hit,
  output logic                  hpm_error,
  output logic [31:0]           hpm_dout,
  input  logic                  wb_retire,
  input  logic [NUM_EVENTS-1:0] hpm_events,
  output logic                  hpm_irq
);

  // Arrays keep at least one entry so NUM_HPM=0 still elaborates.
  localparam int HN = (NUM_HPM == 0) ? 1 : NUM_HPM;
  // Writable inhibit bits: CY, IR and one per implemented HPM counter.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [CNT_W-1:0] cy_q, cy_d, ir_q, ir_d;
  logic [CNT_W-1:0] hpm_q [HN];
  logic [CNT_W-1:0] hpm_d [HN];
  logic [4:0]       sel_q [HN];
  logic [4:0]       sel_d [HN];
  logic [HN-1:0]    of_q, of_d;
  logic [31:0]      inh_q, inh_d;
  logic             irq_q;

  logic [4:0]  idx;
  logic [5:0]  hidx;
  logic        is_inh, is_evt, is_cnt, cnt_hi, ro, op_nz, we, cnt_wr;
  logic [31:0] rd_val, wdata, ev_pad;
  logic [CNT_W-1:0] cnt_rd;
  logic [63:0] cnt_ext;

  // Replace one 32-bit half of a counter, keeping the other half.
  function automatic logic [CNT_W-1:0] merge_half(input logic [CNT_W-1:0] cur,
                                                  input logic hi, input logic [31:0] w);
    logic [63:0] ext;
    ext = 64'(cur);
    if (hi) ext[63:32] = w;
    else    ext[31:0]  = w;
    return ext[CNT_W-1:0];
  endfunction

  // Address decode: counter windows skip index 1 (time lives elsewhere).
  assign idx    = mem1_csr_addr[4:0];
  assign hidx   = {1'b0, idx} - 6'd3;
  assign is_inh = (mem1_csr_addr == 12'h320);
  assign is_evt = (mem1_csr_addr[11:5] == 7'h19) && (idx >= 5'd3);
  assign is_cnt = ((mem1_csr_addr[11:8] == 4'hB) || (mem1_csr_addr[11:8] == 4'hC)) &&
                  (mem1_csr_addr[6:5] == 2'b00) && (idx != 5'd1);
  assign cnt_hi = mem1_csr_addr[7];
  assign ro     = (mem1_csr_addr[11:10] == 2'b11);
  assign op_nz  = |mem1_csr_write;

  assign hpm_hit   = is_inh | is_evt | is_cnt;
  assign hpm_error = hpm_hit & op_nz & ro;
  assign we        = hpm_hit & op_nz & ~ro;
  assign cnt_wr    = we & is_cnt;
  assign hpm_dout  = rd_val;
  assign hpm_irq   = irq_q;

  // Bit 0 stands for SEL=0 so SEL indexes the padded vector directly; out-of-range SEL reads 0.
  assign ev_pad = 32'(hpm_events) << 1;

  // Read mux; unimplemented indices fall through to 0.
  always_comb begin
    rd_val  = '0;
    cnt_rd  = '0;
    cnt_ext = '0;
    if (is_inh) begin
      rd_val = inh_q;
    end else if (is_evt) begin
      for (int i = 0; i < NUM_HPM; i++) begin
        if (hidx == 6'(i)) rd_val = {of_q[i], 26'd0, sel_q[i]};
      end
    end else if (is_cnt) begin
      if (idx == 5'd0) begin
        cnt_rd = cy_q;
      end else if (idx == 5'd2) begin
        cnt_rd = ir_q;
      end else begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (hidx == 6'(i)) cnt_rd = hpm_q[i];
        end
      end
      cnt_ext = 64'(cnt_rd);
      rd_val  = cnt_hi ? cnt_ext[63:32] : cnt_ext[31:0];
    end
  end

  // Write operand derived from the current read value.
  always_comb begin
    case (mem1_csr_write)
      2'b01:   wdata = mem1_csr_din;
      2'b10:   wdata = rd_val | mem1_csr_din;
      2'b11:   wdata = rd_val & ~mem1_csr_din;
      default: wdata = rd_val;
    endcase
  end

  // Next state: CSR writes beat increments; counting uses the inhibit value held this cycle.
  always_comb begin
    cy_d  = (cnt_wr && idx == 5'd0) ? merge_half(cy_q, cnt_hi, wdata)
                                    : cy_q + {{(CNT_W-1){1'b0}}, ~inh_q[0]};
    ir_d  = (cnt_wr && idx == 5'd2) ? merge_half(ir_q, cnt_hi, wdata)
                                    : ir_q + {{(CNT_W-1){1'b0}}, wb_retire & ~inh_q[2]};
    inh_d = (we && is_inh) ? (wdata & INH_MASK) : inh_q;
    of_d  = of_q;
    for (int i = 0; i < HN; i++) begin
      hpm_d[i] = hpm_q[i];
      sel_d[i] = sel_q[i];
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      logic inc, cw, ew, ovf;
      inc = ~inh_q[3+i] & ev_pad[sel_q[i]];
      cw  = cnt_wr && (idx >= 5'd3) && (hidx == 6'(i));
      ew  = we && is_evt && (hidx == 6'(i));
      ovf = inc & ~cw & (&hpm_q[i]);
      hpm_d[i] = cw ? merge_half(hpm_q[i], cnt_hi, wdata)
                    : hpm_q[i] + {{(CNT_W-1){1'b0}}, inc};
      if (ew) begin
        sel_d[i] = wdata[4:0];
        of_d[i]  = wdata[31] | ovf;
      end else begin
        of_d[i]  = of_q[i] | ovf;
      end
    end
  end

  // State registers; irq follows the OF bits one edge later.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      cy_q  <= '0;
      ir_q  <= '0;
      inh_q <= '0;
      of_q  <= '0;
      irq_q <= 1'b0;
      for (int i = 0; i < HN; i++) begin
        hpm_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      cy_q  <= cy_d;
      ir_q  <= ir_d;
      inh_q <= inh_d;
      of_q  <= of_d;
      irq_q <= |of_q;
      for (int i = 0; i < HN; i++) begin
        hpm_q[i] <= hpm_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end

endmodule
